data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Responder for the CPU's data-memory port. It turns single-cycle `lw`/`sw` accesses into a request/ready handshake toward a slower backing memory and stalls the CPU until each access completes. A one-entry read buffer serves repeated loads from the same word with zero stall. Writes pass straight through to the backing memory.

## Interface
Parameters:
- `HIT_ENABLE`, default 1: 1 enables the one-entry read buffer; 0 sends every read to backing memory.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset (fixed, as already decided).
- `cpu_req`  in  1  CPU data access this cycle (lw or sw); held with address/data until `stall` low.
- `data_memory_we`  in  1  1 = store, 0 = load.
- `data_memory_a`  in  32  byte address.
- `data_memory_wd`  in  32  store data.
- `data_memory_rd`  out  32  load data; valid when `stall` = 0.
- `stall`  out  1  combinational; CPU must hold pc and all state while 1.
- `misaligned_err`  out  1  sticky; set on any request with `a[1:0]` != 0.
- `mem_req`  out  1  registered request to backing memory.
- `mem_we`  out  1  registered write enable.
- `mem_addr`  out  32  registered byte address (bits [1:0] always 0).
- `mem_wdata`  out  32  registered write data.
- `mem_ready`  in  1  backing memory completion; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read data.

## Operation
- State machine: IDLE, BUSY, DONE.
- Read buffer: `buf_valid`, `buf_tag[31:0]`, `buf_data[31:0]`. A hit is `HIT_ENABLE && buf_valid && buf_tag == data_memory_a`.
- IDLE with `cpu_req` = 0:
  - `stall` = 0, `data_memory_rd` = 0.
- IDLE with `cpu_req` and misaligned address:
  - `stall` = 0, `data_memory_rd` = 0; a store is dropped.
  - `misaligned_err` is set on the next edge.
  - No backing access; stay in IDLE.
- IDLE, aligned read hit:
  - `stall` = 0, `data_memory_rd` = `buf_data`; stay in IDLE.
- IDLE, aligned read miss or any aligned write:
  - `stall` = 1.
  - On the edge: latch addr/we/wd into `mem_addr`/`mem_we`/`mem_wdata`, set `mem_req` = 1, go to BUSY.
- BUSY:
  - `stall` = 1; `mem_req` and the `mem_*` outputs are held stable.
  - On an edge with `mem_ready` = 1: clear `mem_req` and go to DONE.
  - Read: `buf_valid` = 1, `buf_tag` = `mem_addr`, `buf_data` = `mem_rdata`.
  - Write: if `buf_valid && buf_tag == mem_addr`, then `buf_data` = `mem_wdata` (buffer is write-through).
- DONE:
  - `stall` = 0; `data_memory_rd` = `buf_data` for a read, 0 for a write.
  - The CPU retires the instruction on this edge. `cpu_req` is ignored; go to IDLE.
- Backing-memory writes never allocate a buffer entry.
- With `HIT_ENABLE` = 0: `buf_valid` is still written, but hits are never taken.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `buf_valid` 0, `misaligned_err` 0.
- Combinational outputs after reset: `stall` follows IDLE rules; `data_memory_rd` is 0 unless a hit.
- Hit latency: 0 stall cycles.
- Miss/write latency: 1 (IDLE) + N (BUSY, until `mem_ready`) + 1 (DONE) cycles with `stall` high for 1+N cycles.
- `mem_ready` high on the first BUSY cycle gives N = 1, i.e. 2 stall cycles.
- `mem_ready` is ignored outside BUSY.
- Back-to-back accesses: the next request is evaluated in the IDLE cycle after DONE; no accesses overlap.
- Reset mid-BUSY or mid-DONE: the next state is IDLE with `mem_req` = 0, and the buffer is invalidated. The backing memory must tolerate an abandoned request; a late `mem_ready` is ignored.
- `misaligned_err` is cleared only by `reset`.

## Test plan
- Reset, then idle with `cpu_req` = 0 -> `stall` 0, `mem_req` 0, `misaligned_err` 0, `data_memory_rd` 0.
- Read 0x100 with backing memory returning 0xDEADBEEF and `mem_ready` on the 3rd BUSY cycle -> `stall` high 4 cycles, then DONE with rd = 0xDEADBEEF; `mem_req` seen for exactly 3 cycles with `mem_addr` = 0x100.
- Repeat read 0x100 -> `stall` 0 in the same cycle, rd = 0xDEADBEEF, `mem_req` stays 0. Same stimulus with `HIT_ENABLE` = 0 -> full miss sequence.
- Write 0x12345678 to 0x100 (`mem_ready` on the first BUSY cycle) -> 2 stall cycles, `mem_we` 1, `mem_wdata` 0x12345678. Then read 0x100 -> zero-stall hit returning 0x12345678. Then read 0x104 -> miss.
- Read 0x102 -> `stall` 0, rd 0, no `mem_req`, `misaligned_err` 1 next cycle and still 1 after a later valid access.
- Assert `reset` in the 2nd BUSY cycle of a read miss -> next cycle IDLE, `mem_req` 0. A `mem_ready` pulse one cycle later has no effect. A following read of the old address misses.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Data-memory responder: converts single-cycle CPU lw/sw into a req/ready
// handshake toward a slower backing memory, with a one-entry read buffer.
module data_memory_ctrl #(
    parameter int HIT_ENABLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        data_memory_we,
    input  logic [31:0] data_memory_a,
    input  logic [31:0] data_memory_wd,
    output logic [31:0] data_memory_rd,
    output logic        stall,
    output logic        misaligned_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic HIT_EN_L = (HIT_ENABLE != 0);

    state_t      state_r;
    state_t      state_s;
    logic        buf_valid_r;
    logic [31:0] buf_tag_r;
    logic [31:0] buf_data_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        misaligned_r;
    logic        aligned_s;
    logic        hit_s;
    logic        start_s;
    logic        misaligned_s;
    logic        complete_s;

    // Next-state decode plus the combinational stall/read-data path.
    always_comb begin
        state_s        = state_r;
        stall          = 1'b0;
        data_memory_rd = 32'd0;
        start_s        = 1'b0;
        misaligned_s   = 1'b0;
        aligned_s      = (data_memory_a[1:0] == 2'b00);
        hit_s          = HIT_EN_L && buf_valid_r && (buf_tag_r == data_memory_a);
        complete_s     = (state_r == ST_BUSY) && mem_ready;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (!aligned_s) begin
                        misaligned_s = 1'b1;
                    end else if (!data_memory_we && hit_s) begin
                        data_memory_rd = buf_data_r;
                    end else begin
                        stall   = 1'b1;
                        start_s = 1'b1;
                        state_s = ST_BUSY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (mem_ready) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                // cpu_req is ignored here; the CPU retires on this edge.
                if (mem_we_r) begin
                    data_memory_rd = 32'd0;
                end else begin
                    data_memory_rd = buf_data_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and backing-memory request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            misaligned_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= data_memory_we;
                mem_addr_r  <= {data_memory_a[31:2], 2'b00};
                mem_wdata_r <= data_memory_wd;
            end else if (complete_s) begin
                mem_req_r <= 1'b0;
            end
            if (misaligned_s) begin
                misaligned_r <= 1'b1;
            end
        end
    end

    // Read buffer: reads allocate, writes only update a matching entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= 32'd0;
            buf_data_r  <= 32'd0;
        end else if (complete_s) begin
            if (!mem_we_r) begin
                buf_valid_r <= 1'b1;
                buf_tag_r   <= mem_addr_r;
                buf_data_r  <= mem_rdata;
            end else if (buf_valid_r && (buf_tag_r == mem_addr_r)) begin
                buf_data_r <= mem_wdata_r;
            end
        end
    end

    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign misaligned_err = misaligned_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl; a second instance with
// the read buffer disabled shares the stimulus and is selected via use_nh.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        use_nh;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] rd_h, rd_n, addr_h, addr_n, wdata_h, wdata_n;
    logic        stall_h, stall_n, err_h, err_n, req_h, req_n, mwe_h, mwe_n;

    logic [31:0] rd_o, maddr_o, mwdata_o;
    logic        stall_o, err_o, req_o, mwe_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.HIT_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req & ~use_nh),
        .data_memory_we(we), .data_memory_a(addr), .data_memory_wd(wd),
        .data_memory_rd(rd_h), .stall(stall_h), .misaligned_err(err_h),
        .mem_req(req_h), .mem_we(mwe_h), .mem_addr(addr_h), .mem_wdata(wdata_h),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    data_memory_ctrl #(.HIT_ENABLE(0)) dut_nh (
        .clk(clk), .reset(reset), .cpu_req(cpu_req & use_nh),
        .data_memory_we(we), .data_memory_a(addr), .data_memory_wd(wd),
        .data_memory_rd(rd_n), .stall(stall_n), .misaligned_err(err_n),
        .mem_req(req_n), .mem_we(mwe_n), .mem_addr(addr_n), .mem_wdata(wdata_n),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    assign rd_o     = use_nh ? rd_n    : rd_h;
    assign stall_o  = use_nh ? stall_n : stall_h;
    assign err_o    = use_nh ? err_n   : err_h;
    assign req_o    = use_nh ? req_n   : req_h;
    assign mwe_o    = use_nh ? mwe_n   : mwe_h;
    assign maddr_o  = use_nh ? addr_n  : addr_h;
    assign mwdata_o = use_nh ? wdata_n : wdata_h;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One CPU access: mem_ready answers on BUSY cycle n_rdy with rdata_ret.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int n_rdy, input logic [31:0] rdata_ret,
                          input logic [31:0] exp_rd, input int exp_stalls, input int exp_req);
        int stalls = 0;
        int reqs   = 0;
        int busy   = 0;
        logic done = 1'b0;
        cpu_req = 1'b1;
        we      = w;
        addr    = a;
        wd      = d;
        for (int c = 0; c < 30; c++) begin
            if (req_o) begin
                busy++;
                reqs++;
                mem_ready = (busy == n_rdy);
                mem_rdata = (busy == n_rdy) ? rdata_ret : 32'hFFFF_FFFF;
                if (busy == 1) begin
                    check_val({tag, "_maddr"}, maddr_o, {a[31:2], 2'b00});
                    check_val({tag, "_mwe"}, {31'd0, mwe_o}, {31'd0, w});
                    if (w) check_val({tag, "_mwdata"}, mwdata_o, d);
                end
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (stall_o) begin
                stalls++;
            end else begin
                check_val({tag, "_rd"}, rd_o, exp_rd);
                done = 1'b1;
            end
            next_cycle();
            if (done) break;
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        check_val({tag, "_stalls"}, stalls, exp_stalls);
        check_val({tag, "_reqcnt"}, reqs, exp_req);
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        use_nh    = 1'b0;
        we        = 1'b0;
        addr      = 32'd0;
        wd        = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check_val("rst_stall", {31'd0, stall_o}, 32'd0);
        check_val("rst_req",   {31'd0, req_o},   32'd0);
        check_val("rst_err",   {31'd0, err_o},   32'd0);
        check_val("rst_rd",    rd_o,             32'd0);
        next_cycle();

        access("miss100", 1'b0, 32'h100, 32'd0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 3);
        access("hit100",  1'b0, 32'h100, 32'd0, 1, 32'd0, 32'hDEAD_BEEF, 0, 0);
        access("wr100",   1'b1, 32'h100, 32'h1234_5678, 1, 32'd0, 32'd0, 2, 1);
        access("hitwr",   1'b0, 32'h100, 32'd0, 1, 32'd0, 32'h1234_5678, 0, 0);
        access("miss104", 1'b0, 32'h104, 32'd0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1);

        access("mis102",  1'b0, 32'h102, 32'd0, 1, 32'd0, 32'd0, 0, 0);
        check_val("mis_err", {31'd0, err_o}, 32'd1);
        access("hit104",  1'b0, 32'h104, 32'd0, 1, 32'd0, 32'hCAFE_F00D, 0, 0);
        check_val("mis_sticky", {31'd0, err_o}, 32'd1);

        // Reset on the second BUSY cycle of a miss.
        cpu_req = 1'b1;
        addr    = 32'h200;
        we      = 1'b0;
        next_cycle();
        check_val("rb_busy1", {31'd0, req_o}, 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_val("rb_req", {31'd0, req_o}, 32'd0);
        check_val("rb_stall", {31'd0, stall_o}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        check_val("late_rdy_req", {31'd0, req_o}, 32'd0);
        check_val("late_rdy_stall", {31'd0, stall_o}, 32'd0);
        access("rb_miss104", 1'b0, 32'h104, 32'd0, 1, 32'h0000_0104, 32'h0000_0104, 2, 1);

        // Same repeated-read stimulus with the buffer disabled.
        use_nh = 1'b1;
        #1;
        access("nh_miss1", 1'b0, 32'h100, 32'd0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2, 1);
        access("nh_miss2", 1'b0, 32'h100, 32'd0, 2, 32'h1111_2222, 32'h1111_2222, 3, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
